// File: rtl/mpu_dispatch.sv
// mpu_dispatch: accepts a thread, looks up its code in thread memory and streams the thread ID plus its
// instructions to the selected TPUs through a 2-entry skid buffer with one-cycle read latency.
module mpu_dispatch #(
    parameter int WIDTH_INSTR     = 64,
    parameter int WIDTH_SIZE_TMEM = 13,
    parameter int WIDTH_THREADID  = 8,
    parameter int NUM_TPU         = 16,
    parameter int WIDTH_NUM_ISSUE = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       I_Req,
    input  logic [WIDTH_THREADID-1:0]  I_ThreadID,
    input  logic [NUM_TPU-1:0]         I_TPU_Mask,
    input  logic                       I_Issue_Full,
    output logic                       O_Ack,
    output logic [WIDTH_NUM_ISSUE-1:0] O_Issue_No,
    output logic                       O_Lookup_Req,
    output logic [WIDTH_THREADID-1:0]  O_Lookup_ID,
    input  logic                       I_Lookup_Valid,
    input  logic [WIDTH_SIZE_TMEM-1:0] I_Lookup_Length,
    input  logic [WIDTH_SIZE_TMEM-1:0] I_Lookup_Address,
    output logic                       O_IMem_Req,
    output logic [WIDTH_SIZE_TMEM-1:0] O_IMem_Addr,
    input  logic [WIDTH_INSTR-1:0]     I_IMem_Instr,
    output logic                       O_Send_Valid,
    output logic [WIDTH_INSTR-1:0]     O_Send_Data,
    output logic [NUM_TPU-1:0]         O_Send_TPUs,
    input  logic                       I_Send_Ready,
    output logic                       O_Busy,
    output logic                       O_Done
);
    typedef enum logic [1:0] {INIT, GETINFO, SEND_THREADID, SEND_INSTRS} state_t;
    state_t state;
    logic [WIDTH_THREADID-1:0]  tid;
    logic [NUM_TPU-1:0]         mask;
    logic [WIDTH_NUM_ISSUE-1:0] issue_cnt;
    logic [WIDTH_SIZE_TMEM-1:0] rd_addr, reads_left, words_left;
    logic [WIDTH_INSTR-1:0]     buf0, buf1;
    logic [1:0]                 count, occ, n;
    logic                       rd_vld, xfer_i, pop, push;
    assign O_Busy       = state != INIT;
    assign O_Lookup_Req = state == GETINFO;
    assign O_Lookup_ID  = tid;
    assign O_IMem_Addr  = rd_addr;
    assign O_Send_Valid = state == SEND_THREADID || (state == SEND_INSTRS && (count != 2'd0 || rd_vld));
    assign O_Send_Data  = state == SEND_THREADID ? {1'b1, {(WIDTH_INSTR-1-WIDTH_THREADID){1'b0}}, tid}
                        : count != 2'd0 ? buf0 : rd_vld ? I_IMem_Instr : '0;
    assign O_Send_TPUs  = O_Send_Valid ? mask : '0;
    assign xfer_i       = state == SEND_INSTRS && O_Send_Valid && I_Send_Ready;
    // A word returning while the buffer is empty and the sink is ready bypasses storage entirely
    assign pop          = xfer_i && count != 2'd0;
    assign push         = rd_vld && !(xfer_i && count == 2'd0);
    assign n            = count - {1'b0, pop};
    // Occupancy including the word in flight from memory; a new read must never overflow the two slots
    assign occ          = count + {1'b0, rd_vld} - {1'b0, xfer_i};
    assign O_IMem_Req   = state == SEND_INSTRS && reads_left != '0 && occ < 2'd2;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= INIT;
            tid        <= '0;
            mask       <= '0;
            issue_cnt  <= '0;
            O_Issue_No <= '0;
            O_Ack      <= 1'b0;
            O_Done     <= 1'b0;
            rd_addr    <= '0;
            reads_left <= '0;
            words_left <= '0;
            rd_vld     <= 1'b0;
            count      <= '0;
            buf0       <= '0;
            buf1       <= '0;
        end else begin
            O_Ack  <= 1'b0;
            O_Done <= 1'b0;
            rd_vld <= O_IMem_Req;
            if (O_IMem_Req) begin
                rd_addr    <= rd_addr + 1'b1;
                reads_left <= reads_left - 1'b1;
            end
            if (pop) buf0 <= buf1;
            if (push && n == 2'd0) buf0 <= I_IMem_Instr;
            if (push && n != 2'd0) buf1 <= I_IMem_Instr;
            count <= n + {1'b0, push};
            case (state)
                INIT: if (I_Req && !I_Issue_Full) begin
                    O_Ack      <= 1'b1;
                    tid        <= I_ThreadID;
                    mask       <= I_TPU_Mask;
                    O_Issue_No <= issue_cnt;
                    issue_cnt  <= issue_cnt + 1'b1;
                    state      <= GETINFO;
                end
                GETINFO: if (I_Lookup_Valid) begin
                    rd_addr    <= I_Lookup_Address;
                    reads_left <= I_Lookup_Length;
                    words_left <= I_Lookup_Length;
                    O_Done     <= I_Lookup_Length == '0;
                    state      <= I_Lookup_Length == '0 ? INIT : SEND_THREADID;
                end
                SEND_THREADID: if (I_Send_Ready) state <= SEND_INSTRS;
                SEND_INSTRS: if (xfer_i) begin
                    words_left <= words_left - 1'b1;
                    if (words_left == WIDTH_SIZE_TMEM'(1)) begin
                        O_Done <= 1'b1;
                        state  <= INIT;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_mpu_dispatch.sv
// tb_mpu_dispatch: randomized dispatch traffic checked against a queue-based model of the expected
// send stream, memory read sequence and issue numbering.
module tb_mpu_dispatch;
    logic        clock = 1'b0, reset = 1'b1;
    logic        I_Req = 1'b0, I_Issue_Full = 1'b0, I_Lookup_Valid = 1'b0, I_Send_Ready = 1'b1;
    logic [7:0]  I_ThreadID = '0;
    logic [15:0] I_TPU_Mask = '0;
    logic [12:0] I_Lookup_Length = '0, I_Lookup_Address = '0;
    logic [63:0] I_IMem_Instr = '0;
    logic        O_Ack, O_Lookup_Req, O_IMem_Req, O_Send_Valid, O_Busy, O_Done;
    logic [3:0]  O_Issue_No;
    logic [7:0]  O_Lookup_ID;
    logic [12:0] O_IMem_Addr;
    logic [63:0] O_Send_Data;
    logic [15:0] O_Send_TPUs;

    mpu_dispatch dut (
        .clock(clock), .reset(reset), .I_Req(I_Req), .I_ThreadID(I_ThreadID), .I_TPU_Mask(I_TPU_Mask),
        .I_Issue_Full(I_Issue_Full), .O_Ack(O_Ack), .O_Issue_No(O_Issue_No), .O_Lookup_Req(O_Lookup_Req),
        .O_Lookup_ID(O_Lookup_ID), .I_Lookup_Valid(I_Lookup_Valid), .I_Lookup_Length(I_Lookup_Length),
        .I_Lookup_Address(I_Lookup_Address), .O_IMem_Req(O_IMem_Req), .O_IMem_Addr(O_IMem_Addr),
        .I_IMem_Instr(I_IMem_Instr), .O_Send_Valid(O_Send_Valid), .O_Send_Data(O_Send_Data),
        .O_Send_TPUs(O_Send_TPUs), .I_Send_Ready(I_Send_Ready), .O_Busy(O_Busy), .O_Done(O_Done)
    );

    always #5 clock = ~clock;

    logic [63:0] mem [8192];
    logic [12:0] rd_log [$];
    logic [63:0] obs [$];
    int          obs_cyc [$];
    int          errors = 0, checks = 0, rmode = 0, cyc = 0;
    int          stab_err = 0, tpu_err = 0, done_cnt = 0, ack_cnt = 0, exp_issue = 0;
    bit          mon_en = 1'b0;
    logic [15:0] cur_mask = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Thread memory: fixed one-cycle read latency
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (O_IMem_Req && !reset) begin
            I_IMem_Instr <= mem[O_IMem_Addr];
            rd_log.push_back(O_IMem_Addr);
        end
    end

    // Sink: drives ready, records transfers, watches stall stability and the TPU field
    initial begin
        logic        pv;
        logic [63:0] pd;
        pv = 1'b0;
        pd = '0;
        forever begin
            @(negedge clock);
            I_Send_Ready = rmode == 0 ? 1'b1 : rmode == 1 ? !I_Send_Ready : 1'($urandom_range(0, 1));
            #1;
            if (mon_en) begin
                if (pv && !(O_Send_Valid && O_Send_Data === pd)) stab_err++;
                if (O_Send_TPUs !== (O_Send_Valid ? cur_mask : 16'h0)) tpu_err++;
                if (O_Send_Valid && I_Send_Ready) begin
                    obs.push_back(O_Send_Data);
                    obs_cyc.push_back(cyc);
                end
                if (O_Done) done_cnt++;
                if (O_Ack) ack_cnt++;
            end
            pv = O_Send_Valid && !I_Send_Ready;
            pd = O_Send_Data;
        end
    end

    task automatic do_req(input logic [7:0] tid, input logic [15:0] mask);
        bit ok;
        ok = 1'b0;
        cur_mask = mask;
        I_ThreadID = tid;
        I_TPU_Mask = mask;
        I_Req = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            #2;
            ok = O_Ack;
        end
        I_Req = 1'b0;
        chk("ack", 64'(ok), 64'd1);
        if (ok) begin
            chk("issue_no", 64'(O_Issue_No), 64'(exp_issue));
            chk("lookup_id", 64'({O_Lookup_Req, O_Lookup_ID}), 64'({1'b1, tid}));
        end
        exp_issue = (exp_issue + 1) % 16;
    endtask

    task automatic do_lookup(input int len, input logic [12:0] addr);
        int d;
        d = $urandom_range(0, 2);
        for (int i = 0; i < d; i++) begin
            @(negedge clock);
            #2;
        end
        I_Lookup_Valid = 1'b1;
        I_Lookup_Length = 13'(len);
        I_Lookup_Address = addr;
        @(negedge clock);
        #2;
        I_Lookup_Valid = 1'b0;
    endtask

    task automatic run_thread(input logic [7:0] tid, input logic [15:0] mask, input int len,
                              input logic [12:0] addr, input int mode);
        logic [63:0] exp [$];
        bit ok;
        int bad;
        rmode = mode;
        obs.delete();
        obs_cyc.delete();
        rd_log.delete();
        stab_err = 0;
        tpu_err = 0;
        done_cnt = 0;
        mon_en = 1'b1;
        if (len > 0) exp.push_back({1'b1, 55'b0, tid});
        for (int i = 0; i < len; i++) exp.push_back(mem[13'(int'(addr) + i)]);
        do_req(tid, mask);
        do_lookup(len, addr);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clock);
            #2;
            ok = done_cnt > 0;
        end
        chk("done_seen", 64'(ok), 64'd1);
        repeat (3) @(negedge clock);
        #2;
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("busy_idle", 64'(O_Busy), 64'd0);
        chk("word_count", 64'(obs.size()), 64'(exp.size()));
        bad = 0;
        foreach (exp[i]) if (i >= obs.size() || obs[i] !== exp[i]) bad++;
        chk("words", 64'(bad), 64'd0);
        chk("read_count", 64'(rd_log.size()), 64'(len));
        bad = 0;
        foreach (rd_log[i]) if (rd_log[i] !== 13'(int'(addr) + i)) bad++;
        chk("read_addrs", 64'(bad), 64'd0);
        chk("stable", 64'(stab_err), 64'd0);
        chk("tpus", 64'(tpu_err), 64'd0);
        if (mode == 0 && len > 0 && obs_cyc.size() == len + 1)
            chk("stream_cycles", 64'(obs_cyc[len] - obs_cyc[0]), 64'(len + 1));
    endtask

    initial begin
        bit ok;
        foreach (mem[i]) mem[i] = {$urandom, $urandom};
        repeat (3) @(negedge clock);
        #2;
        chk("rst_ctrl", 64'({O_Ack, O_Busy, O_Send_Valid, O_Done, O_Lookup_Req, O_IMem_Req}), 64'd0);
        chk("rst_misc", 64'({O_Send_TPUs, O_Issue_No, O_Lookup_ID, O_IMem_Addr}), 64'd0);
        reset = 1'b0;
        run_thread(8'h05, 16'hA5A5, 3, 13'h010, 0);
        if (obs.size() > 0) chk("id_word", obs[0], 64'h8000_0000_0000_0005);
        run_thread(8'h12, 16'h00FF, 4, 13'h1FFE, 0);
        run_thread(8'h7E, 16'h1234, 8, 13'h0400, 1);
        run_thread(8'h3C, 16'hFFFF, 0, 13'h0222, 2);
        I_Issue_Full = 1'b1;
        I_Req = 1'b1;
        ack_cnt = 0;
        repeat (6) @(negedge clock);
        #2;
        chk("no_ack_full", 64'(ack_cnt), 64'd0);
        I_Issue_Full = 1'b0;
        run_thread(8'h44, 16'h8001, 5, 13'h0777, 2);
        for (int t = 0; t < 14; t++)
            run_thread(8'($urandom), 16'($urandom), $urandom_range(1, 12), 13'($urandom), $urandom_range(0, 2));
        rmode = 2;
        obs.delete();
        do_req(8'h33, 16'h0F0F);
        do_lookup(30, 13'h0100);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            #2;
            ok = obs.size() >= 5;
        end
        chk("midstream", 64'(ok), 64'd1);
        #1;
        reset = 1'b1;
        mon_en = 1'b0;
        #1;
        chk("rst_mid_ctrl", 64'({O_Ack, O_Busy, O_Send_Valid, O_Done, O_Lookup_Req, O_IMem_Req}), 64'd0);
        chk("rst_mid_data", O_Send_Data, 64'd0);
        chk("rst_mid_misc", 64'({O_Send_TPUs, O_Issue_No, O_Lookup_ID, O_IMem_Addr}), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        exp_issue = 0;
        run_thread(8'h99, 16'h0003, 6, 13'h1FFC, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
